branch_pc_unit: RTL and testbench

- Sits directly downstream of the branch comparator.
- Drives BrUn from the decoded branch type, consumes BrEq/BrLt, resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, and owns the program counter register.
- Generates the redirect, a multi-cycle flush to squash wrong-path instructions, and a misaligned-target trap.

---
 rtl/branch_pc_unit_if.sv | 34 +++
 rtl/branch_pc_unit.sv | 143 ++++++++++++++
 tb/tb_branch_pc_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pc_unit_if.sv
// Branch/PC bundle between decode, comparator and the branch_pc_unit.
// master drives decode-side inputs; slave is the unit itself.
interface branch_pc_unit_if;
  logic        stall;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        BrEq;
  logic        BrLt;
  logic        BrUn;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic        flush;
  logic        misalign;
  logic [31:0] trap_pc;

  modport master (
    output stall, is_branch, is_jal, is_jalr,
    output funct3, imm, rs1_data, BrEq, BrLt,
    input  BrUn, pc, pc_plus4, taken,
    input  flush, misalign, trap_pc
  );

  modport slave (
    input  stall, is_branch, is_jal, is_jalr,
    input  funct3, imm, rs1_data, BrEq, BrLt,
    output BrUn, pc, pc_plus4, taken,
    output flush, misalign, trap_pc
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution, PC register, redirect flush and misaligned-target trap.
// Optional BRANCH_STATS_EN adds br_count / taken_count statistics ports.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_pc_unit_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       br_count,
  output logic [31:0]       taken_count
`endif
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        mis_q, mis_d;

  logic        cond;
  logic        req;
  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        tgt_mis;

  assign pc_plus4 = pc_q + 32'd4;
  assign jalr_sum = bus.rs1_data + bus.imm;

  always_comb begin
    cond = 1'b0;
    case (bus.funct3)
      3'b000:  cond = bus.BrEq;
      3'b001:  cond = ~bus.BrEq;
      3'b100:  cond = bus.BrLt;
      3'b101:  cond = ~bus.BrLt;
      3'b110:  cond = bus.BrLt;
      3'b111:  cond = ~bus.BrLt;
      default: cond = 1'b0;
    endcase
  end

  assign req     = (bus.is_branch & cond) | bus.is_jal | bus.is_jalr;
  assign taken   = req & (state_q == RUN);
  assign target  = bus.is_jalr ? {jalr_sum[31:1], 1'b0}
                               : pc_q + bus.imm;
  assign tgt_mis = target[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    mis_d     = 1'b0;
    if (!bus.stall) begin
      unique case (state_q)
        RUN: begin
          if (taken) begin
            state_d = FLUSH;
            cnt_d   = 4'(FLUSH_CYCLES);
            if (tgt_mis) begin
              pc_d      = TRAP_VEC;
              trap_pc_d = pc_q;
              mis_d     = 1'b1;
            end else begin
              pc_d = target;
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
        FLUSH: begin
          pc_d  = pc_plus4;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= 4'd0;
      pc_q      <= RESET_PC;
      trap_pc_q <= 32'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.BrUn     = bus.funct3[1];
  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.taken    = taken;
  assign bus.flush    = (state_q == FLUSH);
  assign bus.misalign = mis_q;
  assign bus.trap_pc  = trap_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] tk_cnt_q, tk_cnt_d;
  logic        is_cf;

  assign is_cf = bus.is_branch | bus.is_jal | bus.is_jalr;

  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (!bus.stall && state_q == RUN && is_cf) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (taken) tk_cnt_d = tk_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= 32'd0;
      tk_cnt_q <= 32'd0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: redirect, flush, trap, stall, reset.
// Stats ports are checked only when BRANCH_STATS_EN is defined.
module tb_branch_pc_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  branch_pc_unit_if bif();

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count;
  logic [31:0] taken_count;
`endif

  branch_pc_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
`ifdef BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.is_branch = 1'b0;
    bif.is_jal    = 1'b0;
    bif.is_jalr   = 1'b0;
    bif.funct3    = 3'b000;
    bif.imm       = 32'd0;
    bif.rs1_data  = 32'd0;
    bif.BrEq      = 1'b0;
    bif.BrLt      = 1'b0;
  endtask

  initial begin
    int n;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bif.stall = 1'b0;
    idle();
    #3;
    chk("rst_pc", bif.pc, 32'h0);
    chk("rst_flush", 32'(bif.flush), 32'd0);
    chk("rst_mis", 32'(bif.misalign), 32'd0);
    chk("rst_trap_pc", bif.trap_pc, 32'h0);
    #9 rst_n = 1'b1;
    chk("run_pc0", bif.pc, 32'h0);
    tick();
    chk("run_pc4", bif.pc, 32'h4);
    tick();
    chk("run_pc8", bif.pc, 32'h8);

    n = 0;
    while (bif.pc != 32'h40 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_40", bif.pc, 32'h40);

    // BEQ taken
    bif.is_branch = 1'b1;
    bif.funct3    = 3'b000;
    bif.imm       = 32'h20;
    bif.BrEq      = 1'b1;
    #1;
    chk("beq_taken", 32'(bif.taken), 32'd1);
    chk("beq_brun", 32'(bif.BrUn), 32'd0);
    tick();
    idle();
    chk("beq_pc", bif.pc, 32'h60);
    chk("beq_fl1", 32'(bif.flush), 32'd1);
    tick();
    chk("beq_pc64", bif.pc, 32'h64);
    chk("beq_fl2", 32'(bif.flush), 32'd1);
    tick();
    chk("beq_pc68", bif.pc, 32'h68);
    chk("beq_fl_end", 32'(bif.flush), 32'd0);

    // BEQ not taken
    bif.is_branch = 1'b1;
    bif.funct3    = 3'b000;
    bif.imm       = 32'h20;
    bif.BrEq      = 1'b0;
    #1;
    chk("beq_nt", 32'(bif.taken), 32'd0);
    tick();
    chk("beq_nt_pc", bif.pc, 32'h6c);
    chk("beq_nt_fl", 32'(bif.flush), 32'd0);

    // reserved funct3 never redirects
    bif.funct3 = 3'b010;
    bif.BrEq   = 1'b1;
    bif.BrLt   = 1'b1;
    #1;
    chk("f010_nt", 32'(bif.taken), 32'd0);
    tick();
    chk("f010_pc", bif.pc, 32'h70);

    // BGEU taken, then a second taken branch during flush
    bif.funct3 = 3'b111;
    bif.BrEq   = 1'b0;
    bif.BrLt   = 1'b0;
    bif.imm    = 32'h10;
    #1;
    chk("bgeu_brun", 32'(bif.BrUn), 32'd1);
    chk("bgeu_taken", 32'(bif.taken), 32'd1);
    tick();
    chk("bgeu_pc", bif.pc, 32'h80);
    chk("fl_gate", 32'(bif.taken), 32'd0);
    tick();
    chk("fl_ign_pc", bif.pc, 32'h84);
    idle();
    tick();
    chk("fl_ign_pc2", bif.pc, 32'h88);
    chk("fl_ign_fl", 32'(bif.flush), 32'd0);

    // BLT signed
    bif.is_branch = 1'b1;
    bif.funct3    = 3'b100;
    bif.BrLt      = 1'b1;
    #1;
    chk("blt_brun", 32'(bif.BrUn), 32'd0);
    chk("blt_taken", 32'(bif.taken), 32'd1);
    bif.funct3 = 3'b101;
    #1;
    chk("bge_nt", 32'(bif.taken), 32'd0);
    idle();

    // JALR aligned, bit0 masked
    bif.is_jalr  = 1'b1;
    bif.rs1_data = 32'h1001;
    bif.imm      = 32'h3;
    #1;
    chk("jalr_taken", 32'(bif.taken), 32'd1);
    chk("jalr_link", bif.pc_plus4, 32'h8c);
    tick();
    idle();
    chk("jalr_pc", bif.pc, 32'h1004);
    chk("jalr_nomis", 32'(bif.misalign), 32'd0);
    tick();
    tick();
    chk("jalr_pc2", bif.pc, 32'h100c);

    // JALR misaligned -> trap
    bif.is_jalr  = 1'b1;
    bif.rs1_data = 32'h1000;
    bif.imm      = 32'h2;
    tick();
    idle();
    chk("trap_mis", 32'(bif.misalign), 32'd1);
    chk("trap_pc", bif.trap_pc, 32'h100c);
    chk("trap_vec", bif.pc, 32'h100);
    chk("trap_fl", 32'(bif.flush), 32'd1);
    tick();
    chk("trap_mis_off", 32'(bif.misalign), 32'd0);
    chk("trap_pc104", bif.pc, 32'h104);
    tick();
    chk("trap_pc108", bif.pc, 32'h108);

    // JAL held by stall
    bif.is_jal = 1'b1;
    bif.imm    = 32'h40;
    bif.stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bif.pc, 32'h108);
      chk("stall_fl", 32'(bif.flush), 32'd0);
    end
    bif.stall = 1'b0;
    tick();
    idle();
    chk("stall_redir", bif.pc, 32'h148);
    bif.stall = 1'b1;
    tick();
    tick();
    chk("fstall_pc", bif.pc, 32'h148);
    chk("fstall_fl", 32'(bif.flush), 32'd1);
    bif.stall = 1'b0;
    tick();
    chk("fstall_pc2", bif.pc, 32'h14c);
    chk("fstall_fl2", 32'(bif.flush), 32'd1);
    tick();
    chk("fstall_pc3", bif.pc, 32'h150);
    chk("fstall_end", 32'(bif.flush), 32'd0);

`ifdef BRANCH_STATS_EN
    chk("st_br", br_count, 32'd7);
    chk("st_tk", taken_count, 32'd5);
`endif

    // reset while flushing
    bif.is_jal = 1'b1;
    bif.imm    = 32'h8;
    tick();
    idle();
    chk("rf_fl", 32'(bif.flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_pc", bif.pc, 32'h0);
    chk("rf_flush", 32'(bif.flush), 32'd0);
    chk("rf_trap", bif.trap_pc, 32'h0);
`ifdef BRANCH_STATS_EN
    chk("rf_br", br_count, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("rf_run", bif.pc, 32'h4);

    // pc_plus4 wrap-around
    bif.is_jalr  = 1'b1;
    bif.rs1_data = 32'hFFFF_FFF0;
    bif.imm      = 32'hC;
    tick();
    idle();
    chk("wrap_pc", bif.pc, 32'hFFFF_FFFC);
    chk("wrap_p4", bif.pc_plus4, 32'h0);
    tick();
    chk("wrap_adv", bif.pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
